bram_sp_arb: RTL

- Two-requester controller that shares one single-port synchronous BRAM (1-cycle read latency, write-first read-during-write) between ports A and B.
- Optionally zero-fills the whole memory after reset, then arbitrates per-cycle accesses round-robin.
- Returns read data with a fixed latency.
- Sits between two client datapaths and one BRAM instance, driving the BRAM's wr/addr/din and consuming its dout.

---
 rtl/bram_sp_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bram_sp_arb.sv
// Round-robin front end that shares one single-port BRAM between two
// requesters. It can zero-fill the memory after reset, then grants at
// most one request per cycle and returns read data one cycle later.
//
// state  | meaning
// S_HOLD | first cycle after reset, everything quiet
// S_INIT | zero-fill sweep, one word per cycle
// S_RUN  | normal arbitration between ports A and B
module bram_sp_arb #(
    parameter int DATA_WIDTH     = 72,
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_wr,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_din,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_dout,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_wr,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_din,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_dout,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  init_done
);

    typedef enum logic [1:0] {S_HOLD, S_INIT, S_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_b_q, last_b_d;   // 1: B was granted last
    logic                  a_rsp_q, b_rsp_q;
    logic                  grant_a, grant_b;

    // Next state, arbitration and BRAM drive; rst forces everything quiet
    // in the same cycle because the reset is sampled only at the edge.
    always_comb begin
        state_d  = state_q;
        clr_d    = clr_q;
        last_b_d = last_b_q;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = addr_q;
        mem_din  = '0;
        case (state_q)
            S_HOLD: begin
                state_d = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
            end
            S_INIT: begin
                mem_wr   = 1'b1;
                mem_addr = clr_q;
                clr_d    = clr_q + 1'b1;
                if (clr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (a_req_valid && (!b_req_valid || last_b_q)) begin
                    grant_a = 1'b1;
                end else if (b_req_valid) begin
                    grant_b = 1'b1;
                end
                if (grant_a) begin
                    mem_wr   = a_req_wr;
                    mem_addr = a_req_addr;
                    mem_din  = a_req_din;
                    last_b_d = 1'b0;
                end else if (grant_b) begin
                    mem_wr   = b_req_wr;
                    mem_addr = b_req_addr;
                    mem_din  = b_req_din;
                    last_b_d = 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
        if (rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
            mem_wr  = 1'b0;
        end
    end

    // State, sweep counter, held address, fairness bit and response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_HOLD;
            clr_q    <= '0;
            addr_q   <= '0;
            last_b_q <= 1'b1;
            a_rsp_q  <= 1'b0;
            b_rsp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            addr_q   <= mem_addr;
            last_b_q <= last_b_d;
            a_rsp_q  <= grant_a & ~a_req_wr;
            b_rsp_q  <= grant_b & ~b_req_wr;
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign a_rsp_valid = a_rsp_q & ~rst;
    assign b_rsp_valid = b_rsp_q & ~rst;
    assign a_rsp_dout  = mem_dout;
    assign b_rsp_dout  = mem_dout;
    assign init_done   = (state_q == S_RUN) & ~rst;

endmodule
